// File: rtl/mbgd_apb_master.sv
// APB initiator: single read/write commands in over valid/ready, one response pulse out each.
// Optional ACCESS-phase timeout is built when MBGD_APB_MASTER_TIMEOUT_EN is defined.
module mbgd_apb_master #(
  parameter int unsigned ADDR    = 8,
  parameter int unsigned DATA    = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            apb_pclk,
  input  logic            resetn,
  // Command port
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [ADDR-1:0] cmd_addr,
  input  logic [DATA-1:0] cmd_wdata,
  // Response port
  output logic            rsp_valid,
  output logic [DATA-1:0] rsp_rdata,
  output logic            rsp_err,
  // APB initiator
  output logic            apb_psel,
  output logic            apb_penable,
  output logic            apb_pwrite,
  output logic [ADDR-1:0] apb_paddress,
  output logic [DATA-1:0] apb_pwdata,
  input  logic            apb_pready,
  input  logic [DATA-1:0] apb_prdata,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSetup  = 2'b01,
    StAccess = 2'b10,
    StBad    = 2'b11
  } state_e;

  state_e            state_q;
  logic              psel_q;
  logic              penable_q;
  // APB address/control registers double as the command holding registers.
  logic              pwrite_q;
  logic [ADDR-1:0]   paddr_q;
  logic [DATA-1:0]   pwdata_q;
  logic              rsp_valid_q;
  logic [DATA-1:0]   rsp_rdata_q;

`ifdef MBGD_APB_MASTER_TIMEOUT_EN
  localparam logic [8:0] TimeoutLimit = 9'(TIMEOUT);

  logic              rsp_err_q;
  logic [7:0]        wait_cnt_q;
  logic              timeout_hit;

  // Abort when this pready-low cycle would bring the wait count up to the limit.
  assign timeout_hit = ({1'b0, wait_cnt_q} + 9'd1) >= TimeoutLimit;
`endif

  always_ff @(posedge apb_pclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef MBGD_APB_MASTER_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= 8'd0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef MBGD_APB_MASTER_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            state_q  <= StSetup;
            psel_q   <= 1'b1;
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
`ifdef MBGD_APB_MASTER_TIMEOUT_EN
            wait_cnt_q <= 8'd0;
`endif
          end
        end
        StSetup: begin
          state_q   <= StAccess;
          penable_q <= 1'b1;
        end
        StAccess: begin
          if (apb_pready) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : apb_prdata;
            state_q     <= StIdle;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
          end
`ifdef MBGD_APB_MASTER_TIMEOUT_EN
          else if (timeout_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= StIdle;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
          end else if (wait_cnt_q != 8'hFF) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end
        default: begin
          // Illegal encoding: drop the bus and return to IDLE without a response.
          state_q   <= StIdle;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          pwrite_q  <= 1'b0;
          paddr_q   <= '0;
          pwdata_q  <= '0;
        end
      endcase
    end
  end

  // Gated with resetn so the port reads 0 while reset is held.
  assign cmd_ready    = resetn && (state_q == StIdle);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign apb_psel     = psel_q;
  assign apb_penable  = penable_q;
  assign apb_pwrite   = pwrite_q;
  assign apb_paddress = paddr_q;
  assign apb_pwdata   = pwdata_q;
  assign state        = state_q;

`ifdef MBGD_APB_MASTER_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mbgd_apb_master.sv
// Self-checking bench for mbgd_apb_master: directed vector table, multi-cycle sequences and
// randomized commands against a transaction-level model. Timeout checks need MBGD_APB_MASTER_TIMEOUT_EN.
module tb_mbgd_apb_master;

`ifdef MBGD_APB_MASTER_TIMEOUT_EN
  localparam int unsigned Tmo      = 4;
  localparam int          MaxWaits = 3;
`else
  localparam int unsigned Tmo      = 16;
  localparam int          MaxWaits = 5;
`endif

  typedef struct {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic [7:0] prdata;
    logic       hold;
    logic [7:0] exp_rdata;
  } vec_t;

  logic       apb_pclk;
  logic       resetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       apb_psel;
  logic       apb_penable;
  logic       apb_pwrite;
  logic [7:0] apb_paddress;
  logic [7:0] apb_pwdata;
  logic       apb_pready;
  logic [7:0] apb_prdata;
  logic [1:0] state;

  mbgd_apb_master #(
    .ADDR   (8),
    .DATA   (8),
    .TIMEOUT(Tmo)
  ) dut (
    .apb_pclk    (apb_pclk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .apb_psel    (apb_psel),
    .apb_penable (apb_penable),
    .apb_pwrite  (apb_pwrite),
    .apb_paddress(apb_paddress),
    .apb_pwdata  (apb_pwdata),
    .apb_pready  (apb_pready),
    .apb_prdata  (apb_prdata),
    .state       (state)
  );

  initial apb_pclk = 1'b0;
  always #5 apb_pclk = ~apb_pclk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_rdata = 8'h00;
  vec_t       vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rule: reads return the slave data, writes return zero.
  function automatic logic [7:0] model_rdata(input logic write, input logic [7:0] prdata);
    return write ? 8'h00 : prdata;
  endfunction

  // Entered at a negedge with the DUT idle; returns at the negedge of the response cycle.
  task automatic run_cmd(input vec_t v, input string tag);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_rdata_hold"}, 32'(rsp_rdata), 32'(last_rdata));
    cmd_valid  = 1'b1;
    cmd_write  = v.write;
    cmd_addr   = v.addr;
    cmd_wdata  = v.wdata;
    apb_pready = 1'b0;
    apb_prdata = 8'($urandom);
    @(negedge apb_pclk);
    if (v.hold) begin
      cmd_addr  = 8'($urandom);
      cmd_wdata = 8'($urandom);
      cmd_write = 1'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
    check({tag, "_setup_state"}, 32'(state), 32'd1);
    check({tag, "_setup_psel"}, 32'(apb_psel), 32'd1);
    check({tag, "_setup_penable"}, 32'(apb_penable), 32'd0);
    check({tag, "_setup_addr"}, 32'(apb_paddress), 32'(v.addr));
    check({tag, "_setup_pwrite"}, 32'(apb_pwrite), 32'(v.write));
    check({tag, "_setup_busy"}, 32'(cmd_ready), 32'd0);
    check({tag, "_setup_norsp"}, 32'(rsp_valid), 32'd0);
    if (v.write) check({tag, "_setup_pwdata"}, 32'(apb_pwdata), 32'(v.wdata));
    for (int i = 0; i <= v.waits; i++) begin
      @(negedge apb_pclk);
      if (v.hold) cmd_addr = 8'($urandom);
      check({tag, "_acc_state"}, 32'(state), 32'd2);
      check({tag, "_acc_psel"}, 32'(apb_psel), 32'd1);
      check({tag, "_acc_penable"}, 32'(apb_penable), 32'd1);
      check({tag, "_acc_addr"}, 32'(apb_paddress), 32'(v.addr));
      check({tag, "_acc_pwrite"}, 32'(apb_pwrite), 32'(v.write));
      check({tag, "_acc_norsp"}, 32'(rsp_valid), 32'd0);
      if (v.write) check({tag, "_acc_pwdata"}, 32'(apb_pwdata), 32'(v.wdata));
      apb_pready = (i == v.waits);
      apb_prdata = (i == v.waits) ? v.prdata : 8'($urandom);
    end
    @(negedge apb_pclk);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(v.exp_rdata));
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_rsp_state"}, 32'(state), 32'd0);
    check({tag, "_rsp_psel"}, 32'(apb_psel), 32'd0);
    check({tag, "_rsp_penable"}, 32'(apb_penable), 32'd0);
    check({tag, "_rsp_addr"}, 32'(apb_paddress), 32'd0);
    apb_pready = 1'b0;
    cmd_valid  = 1'b0;
    last_rdata = v.exp_rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    resetn     = 1'b0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = 8'h00;
    cmd_wdata  = 8'h00;
    apb_pready = 1'b0;
    apb_prdata = 8'h00;

    // write, addr, wdata, waits, prdata, hold, exp_rdata
    vecs.push_back('{1'b1, 8'h00, 8'hA5, 0, 8'h77, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'h01, 8'h00, 3, 8'h3C, 1'b0, 8'h3C});
    vecs.push_back('{1'b1, 8'h14, 8'h07, 0, 8'h11, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 8'h18, 8'h5A, 0, 8'h22, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'h18, 8'h00, 0, 8'h5A, 1'b0, 8'h5A});
    vecs.push_back('{1'b1, 8'h2B, 8'hC3, 2, 8'hFF, 1'b1, 8'h00});
    vecs.push_back('{1'b0, 8'h33, 8'h99, 1, 8'h81, 1'b1, 8'h81});
    vecs.push_back('{1'b0, 8'hFF, 8'h00, 0, 8'h00, 1'b1, 8'h00});
`ifdef MBGD_APB_MASTER_TIMEOUT_EN
    // pready on the same cycle the limit is reached is still a success.
    vecs.push_back('{1'b0, 8'h05, 8'h00, 3, 8'hE1, 1'b0, 8'hE1});
`else
    // Without the timeout, ACCESS waits well past TIMEOUT cycles.
    vecs.push_back('{1'b0, 8'h05, 8'h00, 20, 8'hE1, 1'b0, 8'hE1});
`endif

    @(negedge apb_pclk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_psel", 32'(apb_psel), 32'd0);
    check("rst_penable", 32'(apb_penable), 32'd0);
    check("rst_pwrite", 32'(apb_pwrite), 32'd0);
    check("rst_paddr", 32'(apb_paddress), 32'd0);
    check("rst_pwdata", 32'(apb_pwdata), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    @(negedge apb_pclk);
    resetn = 1'b1;
    #1;
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge apb_pclk);

    // Directed table, applied back to back (3-cycle spacing when waits are 0).
    for (int i = 0; i < vecs.size(); i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Idle cycle: no spurious response, data held.
    @(negedge apb_pclk);
    check("idle_norsp", 32'(rsp_valid), 32'd0);
    check("idle_psel", 32'(apb_psel), 32'd0);

`ifdef MBGD_APB_MASTER_TIMEOUT_EN
    // Slave never ready: abort after Tmo ACCESS cycles.
    cmd_valid  = 1'b1;
    cmd_write  = 1'b0;
    cmd_addr   = 8'h42;
    apb_pready = 1'b0;
    apb_prdata = 8'hEE;
    @(negedge apb_pclk);
    cmd_valid = 1'b0;
    check("tmo_setup", 32'(state), 32'd1);
    for (int i = 0; i < int'(Tmo); i++) begin
      @(negedge apb_pclk);
      check("tmo_acc_state", 32'(state), 32'd2);
      check("tmo_acc_norsp", 32'(rsp_valid), 32'd0);
      check("tmo_acc_addr", 32'(apb_paddress), 32'h42);
    end
    @(negedge apb_pclk);
    check("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
    check("tmo_rsp_err", 32'(rsp_err), 32'd1);
    check("tmo_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("tmo_state", 32'(state), 32'd0);
    check("tmo_psel", 32'(apb_psel), 32'd0);
    check("tmo_ready", 32'(cmd_ready), 32'd1);
    last_rdata = 8'h00;
    @(negedge apb_pclk);
    check("tmo_err_pulse", 32'(rsp_err), 32'd0);
    check("tmo_valid_pulse", 32'(rsp_valid), 32'd0);
`endif

    // Reset asserted mid-ACCESS: bus drops at once, no response, command lost.
    cmd_valid  = 1'b1;
    cmd_write  = 1'b1;
    cmd_addr   = 8'h66;
    cmd_wdata  = 8'h12;
    apb_pready = 1'b0;
    @(negedge apb_pclk);
    cmd_valid = 1'b0;
    @(negedge apb_pclk);
    check("rstmid_in_access", 32'(state), 32'd2);
    #2;
    resetn = 1'b0;
    #1;
    check("rstmid_psel", 32'(apb_psel), 32'd0);
    check("rstmid_penable", 32'(apb_penable), 32'd0);
    check("rstmid_state", 32'(state), 32'd0);
    check("rstmid_norsp", 32'(rsp_valid), 32'd0);
    check("rstmid_ready", 32'(cmd_ready), 32'd0);
    @(negedge apb_pclk);
    check("rstmid_norsp2", 32'(rsp_valid), 32'd0);
    resetn     = 1'b1;
    last_rdata = 8'h00;
    @(negedge apb_pclk);
    check("rstmid_norsp3", 32'(rsp_valid), 32'd0);
    v = '{1'b0, 8'h18, 8'h00, 1, 8'hB4, 1'b0, 8'hB4};
    run_cmd(v, "after_rst");

    // Randomized commands against the transaction model.
    for (int n = 0; n < 40; n++) begin
      v.write     = 1'($urandom);
      v.addr      = 8'($urandom);
      v.wdata     = 8'($urandom);
      v.waits     = int'($urandom_range(MaxWaits, 0));
      v.prdata    = 8'($urandom);
      v.hold      = 1'($urandom);
      v.exp_rdata = model_rdata(v.write, v.prdata);
      run_cmd(v, $sformatf("rnd%0d", n));
      if ($urandom_range(3, 0) == 0) @(negedge apb_pclk);
    end

    @(negedge apb_pclk);
    check("final_norsp", 32'(rsp_valid), 32'd0);
    check("final_rdata_hold", 32'(rsp_rdata), 32'(last_rdata));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
